// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the store buffer.
// Optional store-to-load forwarding is selected by STORE_BUFFER_FWD_EN.
package store_buffer_pkg;

    localparam int unsigned SB_DEPTH = 4;
    localparam int unsigned SB_AW    = 32;
    localparam int unsigned SB_DW    = 32;

    typedef struct packed {
        logic [SB_AW-1:0] addr;
        logic [SB_DW-1:0] data;
    } sb_entry_t;

    // Width of an occupancy counter that can hold the value 'depth'.
    function automatic int unsigned sb_count_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sb_fifo.sv
// Circular FIFO of buffered stores, exposing every slot oldest-first for the address search.
// Slot data is exported only when STORE_BUFFER_FWD_EN is defined.
import store_buffer_pkg::*;

module sb_fifo #(
    parameter int unsigned DEPTH = SB_DEPTH,
    parameter int unsigned AW    = SB_AW,
    parameter type         entry_t = sb_entry_t
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   push,
    input  entry_t                                 push_entry,
    input  logic                                   pop,
    output entry_t                                 head_entry,
    output logic [DEPTH-1:0]                       ent_valid,
    output logic [DEPTH-1:0][AW-1:0]               ent_addr,
`ifdef STORE_BUFFER_FWD_EN
    output logic [DEPTH-1:0][$bits(entry_t)-AW-1:0] ent_data,
`endif
    output logic [sb_count_w(DEPTH)-1:0]           count,
    output logic                                   empty,
    output logic                                   full
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = sb_count_w(DEPTH);

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   head_q;
    logic [PW-1:0]   tail_q;
    logic [CW-1:0]   count_q;

    // Caller guarantees push only when not full and pop only when not empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem_q[tail_q] <= push_entry;
                tail_q        <= tail_q + 1'b1;
            end
            if (pop) begin
                head_q <= head_q + 1'b1;
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // Slot k of the exported view is the k-th oldest entry, so higher k is newer.
    always_comb begin
        ent_valid = '0;
        ent_addr  = '0;
`ifdef STORE_BUFFER_FWD_EN
        ent_data  = '0;
`endif
        for (int unsigned k = 0; k < DEPTH; k++) begin
            ent_valid[k] = CW'(k) < count_q;
            ent_addr[k]  = mem_q[PW'(head_q + PW'(k))].addr;
`ifdef STORE_BUFFER_FWD_EN
            ent_data[k]  = mem_q[PW'(head_q + PW'(k))].data;
`endif
        end
    end

    assign head_entry = mem_q[head_q];
    assign count      = count_q;
    assign empty      = (count_q == '0);
    assign full       = (count_q == CW'(DEPTH));

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer between EX/MEM and data memory; loads own the port first.
// STORE_BUFFER_FWD_EN enables forwarding; otherwise a load hitting a buffered store stalls.
import store_buffer_pkg::*;

module store_buffer #(
    parameter int unsigned DEPTH = SB_DEPTH,
    parameter int unsigned AW    = SB_AW,
    parameter int unsigned DW    = SB_DW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   st_valid,
    input  logic [AW-1:0]          st_addr,
    input  logic [DW-1:0]          st_data,
    input  logic                   ld_valid,
    input  logic [AW-1:0]          ld_addr,
    output logic                   stall,
    output logic                   ld_done,
    output logic [DW-1:0]          ld_data,
    output logic [AW-1:0]          mem_addr,
    output logic [DW-1:0]          mem_wdata,
    output logic                   mem_write,
    output logic                   mem_read,
    input  logic [DW-1:0]          mem_rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    entry_t                  push_entry;
    entry_t                  head_entry;
    logic [DEPTH-1:0]        ent_valid;
    logic [DEPTH-1:0][AW-1:0] ent_addr;
    logic                    full;
    logic                    push;
    logic                    pop;
    logic                    hit;
    logic                    ld_block;
    logic                    ld_accept;
`ifdef STORE_BUFFER_FWD_EN
    logic [DEPTH-1:0][DW-1:0] ent_data;
    logic [DW-1:0]           fwd_data;
`endif

    assign push_entry = '{addr: st_addr, data: st_data};

    sb_fifo #(
        .DEPTH   (DEPTH),
        .AW      (AW),
        .entry_t (entry_t)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head_entry (head_entry),
        .ent_valid  (ent_valid),
        .ent_addr   (ent_addr),
`ifdef STORE_BUFFER_FWD_EN
        .ent_data   (ent_data),
`endif
        .count      (count),
        .empty      (empty),
        .full       (full)
    );

    // Scan oldest to newest so the last match seen is the newest store.
    always_comb begin
        hit = 1'b0;
`ifdef STORE_BUFFER_FWD_EN
        fwd_data = '0;
`endif
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (ent_valid[k] && (ent_addr[k] == ld_addr)) begin
                hit = 1'b1;
`ifdef STORE_BUFFER_FWD_EN
                fwd_data = ent_data[k];
`endif
            end
        end
    end

`ifdef STORE_BUFFER_FWD_EN
    assign ld_block = 1'b0;
`else
    assign ld_block = ld_valid && hit;
`endif

    assign ld_accept = ld_valid && !ld_block;
    assign push      = st_valid && !full;
    assign pop       = !ld_accept && !empty;
    assign stall     = (st_valid && full) || ld_block;

    // A forwarded load still owns the port for its cycle, so the drain waits.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_write = 1'b0;
        mem_read  = 1'b0;
        if (ld_accept) begin
            mem_addr = ld_addr;
            mem_read = !hit;
        end else if (!empty) begin
            mem_addr  = head_entry.addr;
            mem_wdata = head_entry.data;
            mem_write = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ld_done <= 1'b0;
            ld_data <= '0;
        end else begin
            ld_done <= ld_accept;
            if (ld_accept) begin
`ifdef STORE_BUFFER_FWD_EN
                ld_data <= hit ? fwd_data : mem_rdata;
`else
                ld_data <= mem_rdata;
`endif
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed, table-driven bench for store_buffer (DEPTH=4, AW=DW=32), both
// STORE_BUFFER_FWD_EN settings; each row gives one cycle's inputs and expected outputs.
module tb_store_buffer;

    localparam logic [31:0] DC = 32'hFFFF_FFFF;  // mem_addr don't-care marker

    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        stall;
    logic        ld_done;
    logic [31:0] ld_data;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_rdata;
    logic [2:0]  count;
    logic        empty;

    logic [31:0] mem [64];

    int n_vec  = 0;
    int n_miss = 0;

    store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .st_valid  (st_valid),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .ld_valid  (ld_valid),
        .ld_addr   (ld_addr),
        .stall     (stall),
        .ld_done   (ld_done),
        .ld_data   (ld_data),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_write (mem_write),
        .mem_read  (mem_read),
        .mem_rdata (mem_rdata),
        .count     (count),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[5:0]];
    always @(posedge clk) if (mem_write) mem[mem_addr[5:0]] <= mem_wdata;

    typedef struct {
        logic        rst;
        logic        sv;
        logic [31:0] sa;
        logic [31:0] sd;
        logic        lv;
        logic [31:0] la;
        logic        stall;
        int          cnt;
        logic        mw;
        logic        mr;
        logic [31:0] ma;
        logic [31:0] wd;
        logic        done;
        logic [31:0] ldd;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input logic r, input logic sv, input logic [31:0] sa,
                                input logic [31:0] sd, input logic lv, input logic [31:0] la,
                                input logic stl, input int cnt, input logic mw, input logic mr,
                                input logic [31:0] ma, input logic [31:0] wd,
                                input logic dn, input logic [31:0] ldd);
        vec_t v;
        v.rst = r;  v.sv = sv;  v.sa = sa;  v.sd = sd;  v.lv = lv;  v.la = la;
        v.stall = stl;  v.cnt = cnt;  v.mw = mw;  v.mr = mr;  v.ma = ma;  v.wd = wd;
        v.done = dn;  v.ldd = ldd;
        vq.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive_idle();
        rst = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; ld_valid = 1'b0; ld_addr = '0;
    endtask

    task automatic build_table();
        // Reset mid-operation: three stores held in the buffer by concurrent loads.
        add(0, 1, 1, 32'h101, 1, 30,  0, 0, 0, 1, 30, 0,  0, 0);
        add(0, 1, 2, 32'h102, 1, 31,  0, 1, 0, 1, 31, 0,  1, 0);
        add(0, 1, 3, 32'h103, 1, 32,  0, 2, 0, 1, 32, 0,  1, 0);
        add(1, 0, 0, 0,       1, 33,  0, 3, 0, 1, 33, 0,  1, 0);
        add(0, 0, 0, 0,       0, 0,   0, 0, 0, 0, 0,  0,  0, 0);
        add(0, 0, 0, 0,       0, 0,   0, 0, 0, 0, 0,  0,  0, 0);
        // Load miss on empty buffer.
        add(0, 0, 0, 0,       1, 14,  0, 0, 0, 1, 14, 0,  0, 0);
        add(0, 0, 0, 0,       0, 0,   0, 0, 0, 0, 0,  0,  1, 1);
        // Load right after a store to the same address: 5, then 9.
        add(0, 1, 5, 32'hAAAA0001, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef STORE_BUFFER_FWD_EN
        add(0, 0, 0, 0, 1, 5,  0, 1, 0, 0, DC, 0,            0, 0);
        add(0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 5, 32'hAAAA0001,  1, 32'hAAAA0001);
        add(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,             0, 0);
`else
        add(0, 0, 0, 0, 1, 5,  1, 1, 1, 0, 5, 32'hAAAA0001,  0, 0);
        add(0, 0, 0, 0, 1, 5,  0, 0, 0, 1, 5, 0,             0, 0);
        add(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,             1, 32'hAAAA0001);
`endif
        add(0, 1, 9, 32'h33, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef STORE_BUFFER_FWD_EN
        add(0, 0, 0, 0, 1, 9,  0, 1, 0, 0, DC, 0,      0, 0);
        add(0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 9, 32'h33,  1, 32'h33);
        add(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,       0, 0);
`else
        add(0, 0, 0, 0, 1, 9,  1, 1, 1, 0, 9, 32'h33,  0, 0);
        add(0, 0, 0, 0, 1, 9,  0, 0, 0, 1, 9, 0,       0, 0);
        add(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,       1, 32'h33);
`endif
        // Two stores to address 7, then a load of 7.
        add(0, 1, 7, 32'h11, 1, 40,  0, 0, 0, 1, 40, 0,  0, 0);
        add(0, 1, 7, 32'h22, 1, 41,  0, 1, 0, 1, 41, 0,  1, 0);
`ifdef STORE_BUFFER_FWD_EN
        add(0, 0, 0, 0, 1, 7,  0, 2, 0, 0, DC, 0,      1, 0);
        add(0, 0, 0, 0, 0, 0,  0, 2, 1, 0, 7, 32'h11,  1, 32'h22);
        add(0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 7, 32'h22,  0, 0);
        add(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,       0, 0);
`else
        add(0, 0, 0, 0, 1, 7,  1, 2, 1, 0, 7, 32'h11,  1, 0);
        add(0, 0, 0, 0, 1, 7,  1, 1, 1, 0, 7, 32'h22,  0, 0);
        add(0, 0, 0, 0, 1, 7,  0, 0, 0, 1, 7, 0,       0, 0);
        add(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,       1, 32'h22);
`endif
        // Full buffer: loads on 20..23 keep the port busy, fifth store stalls.
        add(0, 1, 50, 32'h50, 1, 20,  0, 0, 0, 1, 20, 0,       0, 0);
        add(0, 1, 51, 32'h51, 1, 21,  0, 1, 0, 1, 21, 0,       1, 0);
        add(0, 1, 52, 32'h52, 1, 22,  0, 2, 0, 1, 22, 0,       1, 0);
        add(0, 1, 53, 32'h53, 1, 23,  0, 3, 0, 1, 23, 0,       1, 0);
        add(0, 1, 54, 32'h54, 1, 20,  1, 4, 0, 1, 20, 0,       1, 0);
        add(0, 1, 54, 32'h54, 0, 0,   1, 4, 1, 0, 50, 32'h50,  1, 0);
        add(0, 1, 54, 32'h54, 0, 0,   0, 3, 1, 0, 51, 32'h51,  0, 0);
        add(0, 0, 0, 0,       0, 0,   0, 3, 1, 0, 52, 32'h52,  0, 0);
        add(0, 0, 0, 0,       0, 0,   0, 2, 1, 0, 53, 32'h53,  0, 0);
        add(0, 0, 0, 0,       0, 0,   0, 1, 1, 0, 54, 32'h54,  0, 0);
        add(0, 0, 0, 0,       0, 0,   0, 0, 0, 0, 0,  0,       0, 0);
    endtask

    initial begin
        int wait_cycles;
        bit seen;

        for (int a = 0; a < 64; a++) mem[a] = '0;
        mem[14] = 32'd1;

        drive_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset count",     32'(count), 0);
        chk("reset empty",     32'(empty), 1);
        chk("reset ld_done",   32'(ld_done), 0);
        chk("reset ld_data",   ld_data, 0);
        chk("reset mem_write", 32'(mem_write), 0);
        chk("reset mem_read",  32'(mem_read), 0);

        build_table();
        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            rst = vq[i].rst;  st_valid = vq[i].sv;  st_addr = vq[i].sa;  st_data = vq[i].sd;
            ld_valid = vq[i].lv;  ld_addr = vq[i].la;
            #1;
            chk($sformatf("row%0d stall", i),     32'(stall),     32'(vq[i].stall));
            chk($sformatf("row%0d count", i),     32'(count),     vq[i].cnt);
            chk($sformatf("row%0d empty", i),     32'(empty),     32'(vq[i].cnt == 0));
            chk($sformatf("row%0d mem_write", i), 32'(mem_write), 32'(vq[i].mw));
            chk($sformatf("row%0d mem_read", i),  32'(mem_read),  32'(vq[i].mr));
            if (vq[i].ma != DC) chk($sformatf("row%0d mem_addr", i), mem_addr, vq[i].ma);
            if (vq[i].mw) chk($sformatf("row%0d mem_wdata", i), mem_wdata, vq[i].wd);
            chk($sformatf("row%0d ld_done", i),   32'(ld_done),   32'(vq[i].done));
            if (vq[i].done) chk($sformatf("row%0d ld_data", i), ld_data, vq[i].ldd);
        end

        // A store accepted in cycle N must not write memory before N+1.
        @(negedge clk);
        drive_idle();
        st_valid = 1'b1; st_addr = 60; st_data = 32'h60;
        #1;
        chk("store same-cycle mem_write", 32'(mem_write), 0);
        @(negedge clk);
        drive_idle();
        wait_cycles = 0;
        seen = 1'b0;
        #1;
        while (!seen && wait_cycles < 8) begin
            if (mem_write && mem_addr == 60) begin
                seen = 1'b1;
            end else begin
                @(negedge clk);
                #1;
                wait_cycles++;
            end
        end
        chk("store drain seen", 32'(seen), 1);
        chk("store drain latency", wait_cycles, 0);
        chk("store drain wdata", mem_wdata, 32'h60);

        // The drained data is then read back from memory.
        @(negedge clk);
        drive_idle();
        ld_valid = 1'b1; ld_addr = 60;
        #1;
        chk("readback mem_read", 32'(mem_read), 1);
        @(negedge clk);
        drive_idle();
        #1;
        chk("readback ld_done", 32'(ld_done), 1);
        chk("readback ld_data", ld_data, 32'h60);
        @(negedge clk);
        #1;
        chk("readback ld_done one cycle", 32'(ld_done), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
